// File: rtl/sseg_scheduler.sv
// -----------------------------------------------------------------------------
// sseg_scheduler
//
// Drives the two-digit multiplexed seven-segment display on the gp header.
// Several client requesters share the display. It is granted round-robin at
// frame boundaries, and an owner keeps it for a minimum number of frames.
// A phase FSM runs LEFT_ON -> BLANK_A -> RIGHT_ON -> BLANK_B. The digit-select
// line only moves while the segments are dark, which prevents ghosting.
//
// Ports
//   clk_25mhz       in   system clock
//   rst_n           in   synchronous active-low reset
//   i_req           in   [NUM_REQ]   level-held display requests
//   i_value         in   [8*NUM_REQ] byte per requester, [7:4] left, [3:0] right
//   o_grant         out  [NUM_REQ]   one-hot current owner, zero when idle
//   o_segs          out  [7]         segments ABCDEFG (bit 6 = A), active high
//   o_digit_select  out              1 = left digit, 0 = right digit
//   o_frame_tick    out              pulse on the first cycle of each frame
// -----------------------------------------------------------------------------
module sseg_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int PHASE_CYCLES    = 8192,
  parameter int BLANK_CYCLES    = 16,
  parameter int MIN_HOLD_FRAMES = 64
) (
  input  logic                   clk_25mhz,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_value,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [6:0]             o_segs,
  output logic                   o_digit_select,
  output logic                   o_frame_tick
);

  localparam int CNT_MAX = (PHASE_CYCLES > BLANK_CYCLES) ? PHASE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int HOLD_W  = $clog2(MIN_HOLD_FRAMES + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MIN_HOLD_FRAMES);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] LEFT_ON  = 2'd0;
  localparam logic [1:0] BLANK_A  = 2'd1;
  localparam logic [1:0] RIGHT_ON = 2'd2;
  localparam logic [1:0] BLANK_B  = 2'd3;

  logic [1:0]         phase, phase_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  // last_idx is the current owner while o_grant is non-zero. It is the most
  // recent owner otherwise, which lets it double as the round-robin pointer.
  logic [IDX_W-1:0]   last_idx, idx_nxt;
  logic [7:0]         snapshot, snap_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [6:0]         segs_nxt;
  logic               sel_nxt;

  logic               boundary, rearb, found;
  logic [IDX_W-1:0]   start_idx, pick_idx;
  logic [IDX_W:0]     cand;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // Phase sequencing.
  // NOTE: every signal assigned in an always_comb gets a default first.
  // Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt + 1'b1;
    case (phase)
      LEFT_ON:  if (cnt == PHASE_LAST) begin phase_nxt = BLANK_A;  cnt_nxt = '0; end
      BLANK_A:  if (cnt == BLANK_LAST) begin phase_nxt = RIGHT_ON; cnt_nxt = '0; end
      RIGHT_ON: if (cnt == PHASE_LAST) begin phase_nxt = BLANK_B;  cnt_nxt = '0; end
      default:  if (cnt == BLANK_LAST) begin phase_nxt = LEFT_ON;  cnt_nxt = '0; end
    endcase
  end

  assign boundary = (phase == BLANK_B) && (cnt == BLANK_LAST);

  // Round-robin search. It starts one past the last owner and wraps without
  // a modulo operator.
  always_comb begin
    start_idx = (last_idx == IDX_LAST) ? '0 : last_idx + 1'b1;
    found     = 1'b0;
    pick_idx  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, start_idx} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && i_req[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign rearb = !(|o_grant) || !i_req[last_idx] || (hold_cnt == HOLD_MAX);

  // Ownership and snapshot. These change only on the frame boundary edge.
  always_comb begin
    grant_nxt = o_grant;
    idx_nxt   = last_idx;
    hold_nxt  = hold_cnt;
    snap_nxt  = snapshot;
    if (boundary) begin
      if (!rearb) begin
        // Here hold_cnt < HOLD_MAX, so the increment saturates on its own.
        hold_nxt = hold_cnt + 1'b1;
        snap_nxt = i_value[8*last_idx +: 8];
      end else if (found) begin
        grant_nxt = NUM_REQ'(1) << pick_idx;
        idx_nxt   = pick_idx;
        hold_nxt  = HOLD_W'(1);
        snap_nxt  = i_value[8*pick_idx +: 8];
      end else begin
        grant_nxt = '0;
        hold_nxt  = '0;
      end
    end
  end

  // Outputs for the phase being entered. They are registered alongside the
  // state, so the outputs line up with the phase they belong to.
  always_comb begin
    segs_nxt = '0;
    if (|grant_nxt) begin
      if (phase_nxt == LEFT_ON)  segs_nxt = decode(snap_nxt[7:4]);
      if (phase_nxt == RIGHT_ON) segs_nxt = decode(snap_nxt[3:0]);
    end
    // The select line moves one edge after the segments go dark.
    sel_nxt = o_digit_select;
    if (phase_nxt == BLANK_A && cnt_nxt == CNT_W'(1)) sel_nxt = 1'b0;
    if (phase_nxt == BLANK_B && cnt_nxt == CNT_W'(1)) sel_nxt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples the pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      phase          <= LEFT_ON;
      cnt            <= '0;
      hold_cnt       <= '0;
      last_idx       <= IDX_LAST;
      snapshot       <= '0;
      o_grant        <= '0;
      o_segs         <= '0;
      o_digit_select <= 1'b1;
      o_frame_tick   <= 1'b0;
    end else begin
      phase          <= phase_nxt;
      cnt            <= cnt_nxt;
      hold_cnt       <= hold_nxt;
      last_idx       <= idx_nxt;
      snapshot       <= snap_nxt;
      o_grant        <= grant_nxt;
      o_segs         <= segs_nxt;
      o_digit_select <= sel_nxt;
      o_frame_tick   <= boundary;
    end
  end

endmodule

// File: tb/tb_sseg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sseg_scheduler
//
// Directed bench for sseg_scheduler with NUM_REQ=3, PHASE=4, BLANK=2, HOLD=2,
// which gives a 12-cycle frame. Inputs change and outputs are sampled on the
// falling edge. fc counts cycles since the last reset release, so fc % 12 is
// the position within the frame.
// -----------------------------------------------------------------------------
module tb_sseg_scheduler;

  logic        clk_25mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic [2:0]  i_req     = '0;
  logic [23:0] i_value   = '0;
  logic [2:0]  o_grant;
  logic [6:0]  o_segs;
  logic        o_digit_select;
  logic        o_frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int fc       = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  sseg_scheduler #(
    .NUM_REQ(3), .PHASE_CYCLES(4), .BLANK_CYCLES(2), .MIN_HOLD_FRAMES(2)
  ) dut (
    .clk_25mhz      (clk_25mhz),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_value        (i_value),
    .o_grant        (o_grant),
    .o_segs         (o_segs),
    .o_digit_select (o_digit_select),
    .o_frame_tick   (o_frame_tick)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (fc=%0d)", tag, obs, exp, fc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_25mhz);
      fc++;
    end
  endtask

  task automatic goto(input int target);
    while (fc < target) step(1);
  endtask

  logic [2:0] rr_grant [1:7];
  logic [6:0] rr_segs  [1:7];

  initial begin
    int c;
    logic [6:0] es;
    logic       esel;

    // Reset and idle frames.
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    check("rst_segs",  o_segs, 7'd0);
    check("rst_grant", o_grant, 3'b000);
    check("rst_sel",   o_digit_select, 1'b1);
    check("rst_tick",  o_frame_tick, 1'b0);
    rst_n = 1'b1;
    fc = 0;
    for (int f = 0; f < 24; f++) begin
      c = fc % 12;
      check("idle_segs",  o_segs, 7'd0);
      check("idle_grant", o_grant, 3'b000);
      check("idle_sel",   o_digit_select, (c >= 5 && c <= 10) ? 1'b0 : 1'b1);
      check("idle_tick",  o_frame_tick, (fc != 0 && c == 0) ? 1'b1 : 1'b0);
      step(1);
    end

    // A single owner showing 3A across a whole frame.
    i_req   = 3'b001;
    i_value = 24'h00003A;
    goto(36);
    for (int f = 0; f < 12; f++) begin
      c = fc % 12;
      if (c <= 3)      es = SEG_3;
      else if (c <= 5) es = 7'd0;
      else if (c <= 9) es = SEG_A;
      else             es = 7'd0;
      esel = (c >= 5 && c <= 10) ? 1'b0 : 1'b1;
      check("own_grant", o_grant, 3'b001);
      check("own_segs",  o_segs, es);
      check("own_sel",   o_digit_select, esel);
      check("own_tick",  o_frame_tick, (c == 0) ? 1'b1 : 1'b0);
      step(1);
    end
    check("keep_grant", o_grant, 3'b001);
    check("keep_segs",  o_segs, SEG_3);

    // A mid-frame value change is held off until the next boundary.
    i_value = 24'h000012;
    goto(60);
    check("regrant_grant", o_grant, 3'b001);
    check("snap12_left",   o_segs, SEG_1);
    step(1);
    i_value = 24'h0000FF;
    goto(62);
    check("midchg_left",  o_segs, SEG_1);
    goto(66);
    check("midchg_right", o_segs, SEG_2);
    goto(72);
    check("ff_grant", o_grant, 3'b001);
    check("ff_left",  o_segs, SEG_F);
    goto(78);
    check("ff_right", o_segs, SEG_F);

    // The owner drops its request in RIGHT_ON while requester 2 waits.
    i_value = 24'hC40050;
    goto(84);
    check("drop_grant0", o_grant, 3'b001);
    check("drop_left",   o_segs, SEG_5);
    goto(90);
    check("drop_right",  o_segs, SEG_0);
    i_req = 3'b100;
    goto(91);
    check("drop_hold_grant", o_grant, 3'b001);
    check("drop_old_snap",   o_segs, SEG_0);
    goto(96);
    check("drop_new_grant", o_grant, 3'b100);
    check("drop_new_left",  o_segs, SEG_C);
    check("drop_new_tick",  o_frame_tick, 1'b1);
    goto(102);
    check("drop_new_right", o_segs, SEG_4);

    // Round-robin with hold, all three requesting from reset.
    i_req   = 3'b111;
    i_value = 24'hC47E3A;
    rst_n   = 1'b0;
    step(2);
    check("rr_rst_grant", o_grant, 3'b000);
    rst_n = 1'b1;
    fc = 0;
    goto(6);
    check("rr_first_idle", o_grant, 3'b000);
    check("rr_first_segs", o_segs, 7'd0);
    rr_grant[1] = 3'b001; rr_segs[1] = SEG_3;
    rr_grant[2] = 3'b001; rr_segs[2] = SEG_3;
    rr_grant[3] = 3'b010; rr_segs[3] = SEG_7;
    rr_grant[4] = 3'b010; rr_segs[4] = SEG_7;
    rr_grant[5] = 3'b100; rr_segs[5] = SEG_C;
    rr_grant[6] = 3'b100; rr_segs[6] = SEG_C;
    rr_grant[7] = 3'b001; rr_segs[7] = SEG_3;
    for (int k = 1; k <= 7; k++) begin
      goto(12 * k);
      check("rr_grant", o_grant, rr_grant[k]);
      check("rr_segs",  o_segs, rr_segs[k]);
    end

    // Reset asserted in RIGHT_ON while requester 1 owns the display.
    goto(108);
    check("mid_owner1", o_grant, 3'b010);
    goto(114);
    check("mid_right", o_segs, SEG_E);
    check("mid_sel",   o_digit_select, 1'b0);
    rst_n = 1'b0;
    step(1);
    check("midrst_grant", o_grant, 3'b000);
    check("midrst_segs",  o_segs, 7'd0);
    check("midrst_sel",   o_digit_select, 1'b1);
    check("midrst_tick",  o_frame_tick, 1'b0);
    rst_n = 1'b1;
    fc = 0;
    goto(11);
    check("post_idle", o_grant, 3'b000);
    goto(12);
    check("post_grant", o_grant, 3'b001);
    check("post_segs",  o_segs, SEG_3);
    check("post_tick",  o_frame_tick, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sseg_scheduler.md
# sseg_scheduler

Controller for the board's two-digit multiplexed seven-segment display. It arbitrates display ownership among several requesters and grants the display round-robin at frame boundaries, honouring a minimum hold time. It also sequences the left/blank/right/blank multiplex so the digit-select line only switches while segments are dark. It sits between the client logic (counters, debug probes) and the gp header pins that drive the display.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- PHASE_CYCLES, 8192: clock cycles a digit is lit per phase (≥2).
- BLANK_CYCLES, 16: clock cycles of dark time between digits (≥2).
- MIN_HOLD_FRAMES, 64: frames a grant is held before voluntary rearbitration (≥1).

Ports:
- clk_25mhz  in  1  system clock, 25 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- i_req  in  NUM_REQ  request for display, bit n = requester n; level-held.
- i_value  in  8*NUM_REQ  byte to show per requester; [8n+7:8n+4] is the left digit, [8n+3:8n] is the right digit.
- o_grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- o_segs  out  7  segments ABCDEFG (bit 6 = A), active high.
- o_digit_select  out  1  1 selects the left digit, 0 selects the right digit.
- o_frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- Phase FSM: LEFT_ON (PHASE_CYCLES) -> BLANK_A (BLANK_CYCLES) -> RIGHT_ON (PHASE_CYCLES) -> BLANK_B (BLANK_CYCLES) -> LEFT_ON. One frame is 2*(PHASE_CYCLES+BLANK_CYCLES) cycles.
- LEFT_ON: o_segs = decode(snapshot[7:4]), o_digit_select = 1. RIGHT_ON: o_segs = decode(snapshot[3:0]), o_digit_select = 0.
- BLANK_x: o_segs = 0 for the whole phase. o_digit_select changes only on the second blank cycle (blank count 1): BLANK_A drives 0, BLANK_B drives 1. Segments and the select line never change on the same edge.
- Decode (ABCDEFG), 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Frame boundary = the edge from BLANK_B into LEFT_ON. The following happen only on that edge:
  - Rearbitration occurs if there is no owner, the owner's i_req is low, or hold_count has reached MIN_HOLD_FRAMES.
  - Otherwise the owner keeps the grant and hold_count increments, saturating at MIN_HOLD_FRAMES.
  - Round-robin search starts at (owner+1) mod NUM_REQ. With no owner, the search starts just after the last owner, or at index 0 after reset.
  - If the search finds no request, o_grant = 0 and the display is idle. An existing owner still requesting with no competitor simply keeps the grant.
  - A new owner, or a re-grant to the same owner, resets hold_count to 1.
  - The snapshot register loads i_value of the resulting owner. Idle loads nothing, and o_segs stays 0 for the whole frame, including the ON phases.
- Owner dropping i_req mid-frame: the current frame completes from the snapshot, then rearbitration occurs at the boundary regardless of hold.
- i_value changes mid-frame are not shown until the next boundary.

## Timing
- All outputs are registered. State, o_grant, the snapshot and o_segs for a new phase all update on the same edge that enters the phase.
- Request-to-grant latency: 1 to 1 frame + 1 cycle (next boundary), longer if the owner's hold has not expired.
- Reset (rst_n low at an edge) forces:
  - phase LEFT_ON with count 0, hold_count 0, rr pointer such that index 0 is searched first;
  - o_segs = 0, o_digit_select = 1, o_grant = 0, o_frame_tick = 0.
- Reset asserted mid-operation takes effect at the next edge from any state. After release, the first frame boundary occurs after one full frame.
- o_frame_tick is high exactly on the LEFT_ON entry cycle, including while idle.
- Counters are sized $clog2 of their maximum and wrap only by FSM reload, never by overflow.

## Test plan
Bench parameters: NUM_REQ=3, PHASE_CYCLES=4, BLANK_CYCLES=2, MIN_HOLD_FRAMES=2 (frame = 12 cycles).
- Reset and idle: rst_n low for 3 cycles, no i_req -> o_segs=0, o_grant=000, o_digit_select toggles 1->0 at cycle 5 of each frame and 0->1 at cycle 11, o_frame_tick every 12 cycles.
- Single owner: i_req=001, i_value[7:0]=8'h3A -> at the next boundary o_grant=001; LEFT_ON o_segs=1111001, RIGHT_ON o_segs=1110111; o_segs=0 on both blank cycles; select changes only on the second blank cycle.
- Round-robin with hold: i_req=111 from reset -> grants 001, 001, 010, 010, 100, 100, 001 on successive frames.
- Owner drop: owner 0 granted, i_req[0] falls in RIGHT_ON of frame 1 with i_req[2]=1 -> frame 1 completes with the old snapshot; the next boundary grants 100 despite hold=1.
- Mid-frame value change: i_value 8'h12 -> 8'hFF during LEFT_ON -> the frame shows 1 then 2; the next frame shows F/F (1000111).
- Reset mid-frame: rst_n low during RIGHT_ON with owner 1 -> next edge gives o_grant=000, o_segs=0, o_digit_select=1; after release, requester 0 wins if it is requesting.
